serial_slice_add_ctrl: RTL
==========================

# serial_slice_add_ctrl

Multi-cycle add/subtract controller that computes a WIDTH-bit sum by sequencing one SLICE-bit ripple-carry adder slice over WIDTH/SLICE beats, LSB slice first. A registered carry chains the beats together. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It lets wide additions reuse a narrow adder datapath at the cost of latency.

## Interface
- WIDTH, 16, operand and result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per beat (width of the adder slice).
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; borrow-in for sub.
- sub  input  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  raw carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- N = WIDTH/SLICE beats. Beat counter width is clog2(N), minimum 1.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, capture a, b_eff = sub ? ~b : b, and carry = cin ^ sub. Clear the beat counter, then go to RUN.
  - RUN: at beat k (k = 0..N-1), {carry, sum[k*SLICE +: SLICE]} = a[k*SLICE +: SLICE] + b_eff[k*SLICE +: SLICE] + carry. Operands may be shift registers instead of indexed slices. After beat N-1, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Result outputs:
  - cout = carry after beat N-1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), registered at the final beat.
- Width rules: all slice arithmetic is SLICE+1 bits wide. There is no truncation other than sum wrapping modulo 2^WIDTH.
- Input handling outside IDLE: inputs are ignored in RUN and DONE. in_valid while in_ready=0 has no effect, and operands are not re-sampled.
- Output stability: sum, cout and ovf are stable throughout DONE. They hold their last values in IDLE until the next accept. During RUN they are not meaningful.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry=0, counter=0.
- Reset mid-operation (RUN or DONE): aborts the operation with no out_valid pulse. The result is discarded. The state after reset is the same as after power-up reset.
- rst and in_valid high in the same cycle: rst wins and no accept occurs.

## Timing
- Accept edge E0: the rising edge where in_valid && in_ready.
- in_ready goes low in the cycle after E0.
- RUN occupies the N cycles after E0. Beat k completes at edge E(k+1).
- out_valid rises after edge EN, so latency is exactly N cycles from accept to out_valid (4 with defaults).
- Result handshake: an edge with out_valid && out_ready returns to IDLE. out_valid=0 and in_ready=1 in the next cycle.
- No same-cycle turnaround. With out_ready held high, the minimum spacing between accepts is N+2 cycles.
- in_ready and out_valid are decoded from the registered state only. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use the defaults (WIDTH=16, SLICE=4).
1. a=0x1234, b=0x0FFF, cin=0, sub=0 -> sum=0x2233, cout=0, ovf=0. out_valid is high exactly 4 cycles after the accept edge.
2. Full carry ripple across every slice: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
3. Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
4. Subtract:
   - sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0.
   - a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
   - a=0x0007, b=0x0005, cin=1 -> sum=0x0001.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE, while driving in_valid=1 with new operands. Required: sum, cout and ovf are unchanged; in_ready=0; the new operands are not taken. After out_ready=1, in_ready=1 in the next cycle, and the next accept produces the correct result.
6. Reset mid-RUN: assert rst for one cycle at beat 2. Required: the next cycle has in_ready=1, out_valid=0 and sum=0, with no result ever presented. A following operation a=0x00FF, b=0x0001 -> sum=0x0100.

Source files
------------

// File: rtl/serial_slice_add_ctrl.sv
// rtl/serial_slice_add_ctrl.sv - multi-cycle add/sub built from one narrow ripple slice
module serial_slice_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [SLICE:0]   slice_res;
  logic             last_beat;

  // Next-state logic: operands shift right one slice per beat, result slices shift in from the top
  always_comb begin
    slice_res   = {1'b0, a_sh_q[SLICE-1:0]} + {1'b0, b_sh_q[SLICE-1:0]}
                + {{SLICE{1'b0}}, carry_q};
    last_beat   = (cnt_q == CW'(N - 1));
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d     = a;
          b_sh_d     = sub ? ~b : b;
          carry_d    = cin ^ sub;
          cnt_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> SLICE;
        b_sh_d  = b_sh_q >> SLICE;
        carry_d = slice_res[SLICE];
        sum_d   = (sum_q >> SLICE) | (WIDTH'(slice_res[SLICE-1:0]) << (WIDTH - SLICE));
        cnt_d   = cnt_q + CW'(1);
        if (last_beat) begin
          // The top slice still holds the operand sign bits at this point
          cout_d      = slice_res[SLICE];
          ovf_d       = (a_sh_q[SLICE-1] == b_sh_q[SLICE-1]) &&
                        (slice_res[SLICE-1] != a_sh_q[SLICE-1]);
          cnt_d       = '0;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
